// File: rtl/mii_frame_gen.sv
// mii_frame_gen: MII transmit frame generator. Emits preamble, SFD,
// Ethernet header, pattern payload and CRC-32 FCS, nibble-serial.
// Ports:
//   mii_tx_clk  25 MHz MII clock, rising edge only
//   rst         synchronous active-high reset
//   start       start pulse (IDLE only)
//   stop        graceful stop request
//   frame_cnt   frames to send, 0 = continuous (latched at start)
//   err_inject  corrupt next frame with one tx_er cycle
//   busy, done, frames_sent   status
//   mii_tx_en, mii_tx_er, mii_tx_da   MII transmit bus
module mii_frame_gen #(
  parameter logic [47:0] DST_MAC      = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC      = 48'h000A_3501_FEC0,
  parameter logic [15:0] ETH_TYPE     = 16'h0800,
  parameter int          PAYLOAD_LEN  = 46,
  parameter int          IFG_NIBBLES  = 24,
  parameter int          PATTERN_MODE = 0,
  parameter logic [7:0]  FILL_BYTE    = 8'hA5
) (
  input  logic        mii_tx_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_cnt,
  input  logic        err_inject,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_sent,
  output logic        mii_tx_en,
  output logic        mii_tx_er,
  output logic [3:0]  mii_tx_da
);

  localparam logic [111:0] HDR_BITS =
    {DST_MAC, SRC_MAC, ETH_TYPE};
  localparam logic [11:0] PAY_LAST =
    12'(2 * PAYLOAD_LEN - 1);
  localparam logic [11:0] IFG_LAST =
    12'(IFG_NIBBLES - 1);
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  if (PAYLOAD_LEN < 46 || PAYLOAD_LEN > 1500)
  begin : g_bad_len
    $error("PAYLOAD_LEN must be 46..1500");
  end

  if (IFG_NIBBLES < 24) begin : g_bad_ifg
    $error("IFG_NIBBLES must be at least 24");
  end

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, HDR, PAY, FCS, IFG
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [31:0] crc, crc_nxt;
  logic [15:0] fc, fc_nxt;
  logic [15:0] sent_nxt;
  logic        stop_req, stop_nxt;
  logic [7:0]  seq, seq_nxt;
  logic        err, err_nxt;
  logic        launch;
  logic        en_nxt, er_nxt;
  logic [3:0]  da_nxt;
  logic [7:0]  hdr_byte, pay_byte;

  // Reflected CRC-32, four bits per call, LSB first.
  function automatic logic [31:0] crc_nib(
    input logic [31:0] c,
    input logic [3:0]  d
  );
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // Sequencing: state/cnt name the nibble currently on the wire;
  // the *_nxt values describe the nibble driven at the next edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 12'd1;
    fc_nxt    = fc;
    sent_nxt  = frames_sent;
    stop_nxt  = stop_req | stop;
    seq_nxt   = seq;
    err_nxt   = err;
    launch    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        stop_nxt = 1'b0;
        if (start) begin
          state_nxt = PRE;
          fc_nxt    = frame_cnt;
          sent_nxt  = '0;
          launch    = 1'b1;
        end
      end
      PRE: if (cnt == 12'd14) begin
        state_nxt = SFD;
        cnt_nxt   = '0;
      end
      SFD: begin
        state_nxt = HDR;
        cnt_nxt   = '0;
      end
      HDR: if (cnt == 12'd27) begin
        state_nxt = PAY;
        cnt_nxt   = '0;
      end
      PAY: if (cnt == PAY_LAST) begin
        state_nxt = FCS;
        cnt_nxt   = '0;
      end
      FCS: if (cnt == 12'd7) begin
        state_nxt = IFG;
        cnt_nxt   = '0;
        sent_nxt  = frames_sent + 16'd1;
      end
      IFG: if (cnt == IFG_LAST) begin
        cnt_nxt = '0;
        if (stop_req || stop ||
            (fc != 16'd0 && frames_sent == fc)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = PRE;
          launch    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Per-frame attributes are frozen when a preamble begins.
    if (launch) begin
      seq_nxt = sent_nxt[7:0];
      err_nxt = err_inject;
    end

    hdr_byte = HDR_BITS[7'd104 - {cnt_nxt[4:1], 3'b000} +: 8];
    pay_byte = (PATTERN_MODE != 0) ? FILL_BYTE
             : cnt_nxt[8:1] + seq_nxt;

    en_nxt  = 1'b0;
    er_nxt  = 1'b0;
    da_nxt  = 4'h0;
    crc_nxt = crc;
    unique case (state_nxt)
      PRE: begin
        en_nxt = 1'b1;
        da_nxt = 4'h5;
      end
      SFD: begin
        en_nxt = 1'b1;
        da_nxt = 4'hD;
      end
      HDR: begin
        en_nxt  = 1'b1;
        da_nxt  = cnt_nxt[0] ? hdr_byte[7:4]
                             : hdr_byte[3:0];
        crc_nxt = crc_nib(
          (state == HDR) ? crc : 32'hFFFF_FFFF, da_nxt);
      end
      PAY: begin
        en_nxt  = 1'b1;
        da_nxt  = cnt_nxt[0] ? pay_byte[7:4]
                             : pay_byte[3:0];
        er_nxt  = err_nxt && (cnt_nxt == 12'd0);
        crc_nxt = crc_nib(crc, da_nxt);
      end
      FCS: begin
        en_nxt  = 1'b1;
        da_nxt  = ~crc[3:0];
        crc_nxt = {4'h0, crc[31:4]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge mii_tx_clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      crc         <= '1;
      fc          <= '0;
      stop_req    <= 1'b0;
      seq         <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
      mii_tx_en   <= 1'b0;
      mii_tx_er   <= 1'b0;
      mii_tx_da   <= 4'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      crc         <= crc_nxt;
      fc          <= fc_nxt;
      stop_req    <= stop_nxt;
      seq         <= seq_nxt;
      err         <= err_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state == IFG) && (state_nxt == IDLE);
      frames_sent <= sent_nxt;
      mii_tx_en   <= en_nxt;
      mii_tx_er   <= er_nxt;
      mii_tx_da   <= da_nxt;
    end
  end

endmodule

// File: tb/tb_mii_frame_gen.sv
// tb_mii_frame_gen: scoreboard bench for mii_frame_gen.
// Two instances: defaults, and 1500-byte constant-fill payload.
module tb_mii_frame_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst;
  logic        start_a, stop_a, err_a;
  logic [15:0] fc_a;
  logic        busy_a, done_a, en_a, er_a;
  logic [15:0] sent_a;
  logic [3:0]  da_a;
  logic        start_b, stop_b, err_b;
  logic [15:0] fc_b;
  logic        busy_b, done_b, en_b, er_b;
  logic [15:0] sent_b;
  logic [3:0]  da_b;

  mii_frame_gen dut_a (
    .mii_tx_clk(clk), .rst(rst),
    .start(start_a), .stop(stop_a),
    .frame_cnt(fc_a), .err_inject(err_a),
    .busy(busy_a), .done(done_a),
    .frames_sent(sent_a),
    .mii_tx_en(en_a), .mii_tx_er(er_a),
    .mii_tx_da(da_a)
  );

  mii_frame_gen #(
    .PAYLOAD_LEN(1500), .PATTERN_MODE(1)
  ) dut_b (
    .mii_tx_clk(clk), .rst(rst),
    .start(start_b), .stop(stop_b),
    .frame_cnt(fc_b), .err_inject(err_b),
    .busy(busy_b), .done(done_b),
    .frames_sent(sent_b),
    .mii_tx_en(en_b), .mii_tx_er(er_b),
    .mii_tx_da(da_b)
  );

  logic        sel;
  logic        m_en, m_er, m_done;
  logic [3:0]  m_da;
  logic [15:0] m_sent;
  assign m_en   = sel ? en_b   : en_a;
  assign m_er   = sel ? er_b   : er_a;
  assign m_done = sel ? done_b : done_a;
  assign m_da   = sel ? da_b   : da_a;
  assign m_sent = sel ? sent_b : sent_a;

  localparam logic [7:0] HDR_B [14] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h00, 8'h0A, 8'h35, 8'h01, 8'hFE, 8'hC0,
    8'h08, 8'h00};

  int checks = 0;
  int errors = 0;
  // {check_data, tx_er, tx_da}
  logic [5:0]  exp_q  [$];
  int          len_q  [$];
  logic [15:0] done_q [$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  function automatic logic [31:0] crc_nib(
    input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'h0, d};
    for (int i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b,
                           input logic er);
    exp_q.push_back({1'b1, er, b[3:0]});
    exp_q.push_back({1'b1, 1'b0, b[7:4]});
  endtask

  task automatic push_frame(input int plen,
                            input bit mode,
                            input logic [7:0] seq,
                            input bit er);
    logic [7:0] b;
    for (int i = 0; i < 15; i++)
      exp_q.push_back({2'b10, 4'h5});
    exp_q.push_back({2'b10, 4'hD});
    for (int i = 0; i < 14; i++)
      push_byte(HDR_B[i], 1'b0);
    for (int k = 0; k < plen; k++) begin
      b = mode ? 8'hA5 : 8'(k) + seq;
      push_byte(b, er && (k == 0));
    end
    for (int i = 0; i < 8; i++)
      exp_q.push_back(6'h00);
    len_q.push_back(16 + 28 + 2 * plen + 8);
  endtask

  // Monitor: consumes the scoreboard on every output cycle.
  int         run_len = 0;
  int         gap_len = 0;
  bit         in_frame = 0;
  bit         gap_on = 0;
  logic [31:0] rcrc = '1;
  logic [5:0]  e;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      gap_on   = 0;
    end else if (m_en) begin
      if (!in_frame) begin
        if (gap_on) chk("ifg_len", 32'(gap_len), 32'd24);
        in_frame = 1;
        gap_on   = 0;
        run_len  = 0;
        rcrc     = '1;
      end
      run_len++;
      if (run_len > 16) rcrc = crc_nib(rcrc, m_da);
      if (exp_q.size() == 0) begin
        fail_now("extra_nibble");
      end else begin
        e = exp_q.pop_front();
        chk("tx_er", 32'(m_er), 32'(e[4]));
        if (e[5]) chk("tx_da", 32'(m_da), 32'(e[3:0]));
      end
    end else begin
      if (in_frame) begin
        in_frame = 0;
        if (len_q.size() == 0) fail_now("extra_frame");
        else chk("tx_en_len", 32'(run_len),
                 32'(len_q.pop_front()));
        chk("crc_residue", rcrc, 32'hDEBB20E3);
        gap_on  = 1;
        gap_len = 0;
      end
      chk("idle_bus", 32'({m_er, m_da}), 32'd0);
      if (m_done) begin
        if (done_q.size() == 0) fail_now("extra_done");
        else chk("frames_sent", 32'(m_sent),
                 32'(done_q.pop_front()));
        chk("done_gap", gap_on ? 32'(gap_len) : 32'd0,
            32'd24);
        gap_on = 0;
      end
      if (gap_on) gap_len++;
    end
  end

  task automatic wait_idle(input int limit,
                           input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0 ||
            done_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size() + len_q.size() +
                  done_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic start_a_pulse(input logic [15:0] n,
                               input logic stp);
    @(posedge clk);
    #1;
    fc_a    = n;
    start_a = 1'b1;
    stop_a  = stp;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    stop_a  = 1'b0;
    fc_a    = 16'd7;
    chk("start_latency_en", 32'(en_a), 32'd1);
    chk("start_busy", 32'(busy_a), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    start_a = 0; stop_a = 0; err_a = 0; fc_a = 0;
    start_b = 0; stop_b = 0; err_b = 0; fc_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_sent", 32'(sent_a), 32'd0);
    chk("rst_en", 32'(en_a), 32'd0);
    chk("rst_er", 32'(er_a), 32'd0);
    chk("rst_da", 32'(da_a), 32'd0);
    chk("rst_en_b", 32'(en_b), 32'd0);
    rst = 1'b0;

    // Single broadcast frame.
    push_frame(46, 0, 8'd0, 0);
    done_q.push_back(16'd1);
    start_a_pulse(16'd1, 1'b0);
    wait_idle(1000, "single_frame_timeout");
    chk("single_busy_end", 32'(busy_a), 32'd0);

    // Three counted frames; stop with start is ignored.
    for (int f = 0; f < 3; f++)
      push_frame(46, 0, 8'(f), 0);
    done_q.push_back(16'd3);
    start_a_pulse(16'd3, 1'b1);
    wait_idle(1000, "three_frame_timeout");

    // Continuous, stop during payload of frame 2.
    for (int f = 0; f < 2; f++)
      push_frame(46, 0, 8'(f), 0);
    done_q.push_back(16'd2);
    start_a_pulse(16'd0, 1'b0);
    repeat (220) @(posedge clk);
    #1;
    stop_a = 1'b1;
    @(posedge clk);
    #1;
    stop_a = 1'b0;
    wait_idle(1000, "stop_timeout");

    // Reset in the middle of the header.
    push_frame(46, 0, 8'd0, 0);
    start_a_pulse(16'd1, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_en", 32'(en_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_sent", 32'(sent_a), 32'd0);
    exp_q.delete();
    len_q.delete();
    done_q.delete();
    rst = 1'b0;
    push_frame(46, 0, 8'd0, 0);
    done_q.push_back(16'd1);
    start_a_pulse(16'd1, 1'b0);
    wait_idle(1000, "post_rst_timeout");

    // Long constant-fill frame with error injection.
    sel = 1'b1;
    push_frame(1500, 1, 8'd0, 1);
    done_q.push_back(16'd1);
    @(posedge clk);
    #1;
    fc_b = 16'd1;
    err_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    err_b = 1'b0;
    fc_b = 16'd0;
    chk("big_latency_en", 32'(en_b), 32'd1);
    for (int p = 0; p < 2; p++) begin
      repeat (900) @(posedge clk);
      #1;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      chk("big_busy", 32'(busy_b), 32'd1);
    end
    wait_idle(4000, "big_frame_timeout");
    chk("big_busy_end", 32'(busy_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
